instr_decode_stage: RTL

INSTR_DECODE_STAGE -- requirements
Module: instr_decode_stage

---
 rtl/instr_decode_stage.sv | 94 +++++++++
 1 files changed

// File: rtl/instr_decode_stage.sv
// instr_decode_stage: MIPS decode stage with a registered output and a one-entry skid buffer
// Ports: clk/rst_n (async active-low), flush (sync discard), in_valid/in_ready + instr/pc in,
//        out_valid/out_ready + opcode/rs/rt/rd/shamt/funct/itype/imm_ext/jtarget out.
module instr_decode_stage #(
  parameter int XLEN = 32,
  parameter bit ZEXT_LOGIC = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [5:0]      opcode,
  output logic [5:0]      funct,
  output logic [4:0]      rs,
  output logic [4:0]      rt,
  output logic [4:0]      rd,
  output logic [4:0]      shamt,
  output logic [1:0]      itype,
  output logic [XLEN-1:0] imm_ext,
  output logic [XLEN-1:0] jtarget
);
  typedef struct packed {
    logic [5:0]      op;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [4:0]      sh;
    logic [5:0]      fn;
    logic [1:0]      ty;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] jt;
  } dec_t;
  dec_t d, o, s;
  logic [5:0] op;
  logic r_ty, j_ty, lg, ld;
  logic [XLEN-1:0] pc4, sx, bofs;
  always_comb begin
    op = instr[31:26];
    r_ty = op == 6'h00;
    j_ty = op == 6'h02 || op == 6'h03;
    lg = ZEXT_LOGIC && op >= 6'h0C && op <= 6'h0E;
    pc4 = pc + XLEN'(4);
    sx = XLEN'($signed(instr[15:0]));
    bofs = XLEN'($signed({instr[15:0], 2'b00}));
    d.op = op;
    d.rs = j_ty ? 5'd0 : instr[25:21];
    d.rt = j_ty ? 5'd0 : instr[20:16];
    d.rd = r_ty ? instr[15:11] : op == 6'h03 ? 5'd31 : 5'd0;
    d.sh = r_ty ? instr[10:6] : 5'd0;
    d.fn = r_ty ? instr[5:0] : 6'd0;
    d.ty = r_ty ? 2'b00 : j_ty ? 2'b10 : 2'b01;
    d.imm = (r_ty || j_ty) ? '0 : op == 6'h0F ? XLEN'($signed({instr[15:0], 16'h0000})) : lg ? XLEN'(instr[15:0]) : sx;
    d.jt = r_ty ? '0 : j_ty ? {pc4[XLEN-1:28], instr[25:0], 2'b00} : pc4 + bofs;
  end
  // the output register may take a new entry when empty or draining this cycle
  assign ld = !out_valid || out_ready;
  // in_ready is its own flop and is the complement of the skid-full state
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      in_ready <= 1'b1;
      o <= '0;
      s <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      in_ready <= 1'b1;
    end else if (ld) begin
      if (!in_ready) begin
        o <= s;
        out_valid <= 1'b1;
        in_ready <= 1'b1;
      end else begin
        out_valid <= in_valid;
        if (in_valid) o <= d;
      end
    end else if (in_valid && in_ready) begin
      s <= d;
      in_ready <= 1'b0;
    end
  assign opcode = o.op;
  assign rs = o.rs;
  assign rt = o.rt;
  assign rd = o.rd;
  assign shamt = o.sh;
  assign funct = o.fn;
  assign itype = o.ty;
  assign imm_ext = o.imm;
  assign jtarget = o.jt;
endmodule
